// File: rtl/vtg_pkg.sv
// Shared types and helpers for the raster timing generator: per-axis phase
// encoding and the line/frame total-length calculation.
package vtg_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FP,
    PH_SYNC,
    PH_BP
  } phase_t;

  function automatic int vtg_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vtg_axis.sv
// One raster axis: ACTIVE -> FP -> SYNC -> BP phase FSM with a phase-local
// down-counter, absolute position counter and registered sync/active decodes.
module vtg_axis
  import vtg_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int POL    = 0,
  parameter int CNT_W  = 10
) (
  input  logic             clk_25,
  input  logic             rst,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync,
  output logic             active
);

  localparam int TOTAL = vtg_total(ACTIVE, FP, SYNC, BP);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_len
    $error("vtg_axis: every phase length must be at least 1");
  end
  if (TOTAL > (2 ** CNT_W)) begin : g_bad_width
    $error("vtg_axis: axis total does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] ACTIVE_M1 = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] FP_M1     = CNT_W'(FP - 1);
  localparam logic [CNT_W-1:0] SYNC_M1   = CNT_W'(SYNC - 1);
  localparam logic [CNT_W-1:0] BP_M1     = CNT_W'(BP - 1);
  localparam logic             SYNC_ON   = (POL != 0);

  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sync_q, sync_d;
  logic             active_q, active_d;
  logic             last_pos;

  // The final position of the axis is the last clock of the back porch.
  assign last_pos = (phase_q == PH_BP) && (left_q == '0);

  always_ff @(posedge clk_25) begin
    if (rst) begin
      phase_q  <= PH_ACTIVE;
      left_q   <= ACTIVE_M1;
      count_q  <= '0;
      sync_q   <= ~SYNC_ON;
      active_q <= 1'b1;
    end else begin
      phase_q  <= phase_d;
      left_q   <= left_d;
      count_q  <= count_d;
      sync_q   <= sync_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    left_d   = left_q;
    count_d  = count_q;
    sync_d   = sync_q;
    active_d = active_q;
    if (tick) begin
      count_d = last_pos ? '0 : count_q + 1'b1;
      if (left_q == '0) begin
        case (phase_q)
          PH_ACTIVE: begin phase_d = PH_FP;     left_d = FP_M1;     end
          PH_FP:     begin phase_d = PH_SYNC;   left_d = SYNC_M1;   end
          PH_SYNC:   begin phase_d = PH_BP;     left_d = BP_M1;     end
          PH_BP:     begin phase_d = PH_ACTIVE; left_d = ACTIVE_M1; end
          default:   begin phase_d = PH_ACTIVE; left_d = ACTIVE_M1; end
        endcase
      end else begin
        left_d = left_q - 1'b1;
      end
      // Decodes follow the next phase so they line up with the next count.
      sync_d   = (phase_d == PH_SYNC) ? SYNC_ON : ~SYNC_ON;
      active_d = (phase_d == PH_ACTIVE);
    end
  end

  assign count  = count_q;
  assign wrap   = last_pos;
  assign sync   = sync_q;
  assign active = active_q;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator (counters, syncs, active, strobes).
// Optional feature macro: VTG_FRAME_CNT_EN adds a 16-bit frame_count output.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CNT_W    = 10
) (
  input  logic             clk_25,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] x_count,
  output logic [CNT_W-1:0] y_count,
  output logic             hsync,
  output logic             vsync,
  output logic             active_pixel,
  output logic             line_start,
  output logic             frame_start
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_count
`endif
);

  logic h_wrap, v_wrap;
  logic h_active, v_active;
  logic tick_v;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  // Vertical advances only on the edge where the line wraps.
  assign tick_v = en & h_wrap;

  vtg_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(H_POL), .CNT_W(CNT_W)
  ) u_h_axis (
    .clk_25 (clk_25),
    .rst    (rst),
    .tick   (en),
    .count  (x_count),
    .wrap   (h_wrap),
    .sync   (hsync),
    .active (h_active)
  );

  vtg_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(V_POL), .CNT_W(CNT_W)
  ) u_v_axis (
    .clk_25 (clk_25),
    .rst    (rst),
    .tick   (tick_v),
    .count  (y_count),
    .wrap   (v_wrap),
    .sync   (vsync),
    .active (v_active)
  );

  assign active_pixel = h_active & v_active;

  always_ff @(posedge clk_25) begin
    if (rst) begin
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (en) begin
      line_start_d  = h_wrap;
      frame_start_d = h_wrap & v_wrap;
    end
  end

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  always_ff @(posedge clk_25) begin
    if (rst) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    frame_count_d = frame_count_q;
    if (en && h_wrap && v_wrap) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised self-checking bench for video_timing_gen against an arithmetic
// raster model (position counters plus interval decodes).
module tb_video_timing_gen;

  localparam int HA = 10, HF = 3, HS = 4, HB = 2;
  localparam int VA = 6,  VF = 2, VS = 3, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int HP = 1, VP = 0;
  localparam int CW = 5;

  logic          clk_25 = 1'b0;
  logic          rst    = 1'b1;
  logic          en     = 1'b0;
  logic [CW-1:0] x_count, y_count;
  logic          hsync, vsync, active_pixel, line_start, frame_start;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0]   frame_count;
`endif

  int checks   = 0;
  int failures = 0;
  int mx = 0, my = 0, mfc = 0;
  int cyc = 0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(HP), .V_POL(VP), .CNT_W(CW)
  ) dut (
    .clk_25       (clk_25),
    .rst          (rst),
    .en           (en),
    .x_count      (x_count),
    .y_count      (y_count),
    .hsync        (hsync),
    .vsync        (vsync),
    .active_pixel (active_pixel),
    .line_start   (line_start),
    .frame_start  (frame_start)
`ifdef VTG_FRAME_CNT_EN
    ,
    .frame_count  (frame_count)
`endif
  );

  always #5 clk_25 = ~clk_25;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d (model x=%0d y=%0d)", tag, cyc, got, exp, mx, my);
    end
  endtask

  // Apply one clock of stimulus, advance the model, then compare mid-cycle.
  task automatic step(input logic en_v, input logic rst_v);
    logic exp_hs, exp_vs;
    en  = en_v;
    rst = rst_v;
    @(posedge clk_25);
    cyc++;
    if (rst_v) begin
      mx = 0; my = 0; mfc = 0;
    end else if (en_v) begin
      if (mx == HT - 1) begin
        mx = 0;
        if (my == VT - 1) begin
          my  = 0;
          mfc = (mfc + 1) % 65536;
        end else begin
          my++;
        end
      end else begin
        mx++;
      end
    end
    #1;
    exp_hs = (mx >= HA + HF && mx < HA + HF + HS) ? 1'(HP) : ~1'(HP);
    exp_vs = (my >= VA + VF && my < VA + VF + VS) ? 1'(VP) : ~1'(VP);
    check_eq("x_count", 32'(x_count), 32'(mx));
    check_eq("y_count", 32'(y_count), 32'(my));
    check_eq("hsync", 32'(hsync), 32'(exp_hs));
    check_eq("vsync", 32'(vsync), 32'(exp_vs));
    check_eq("active_pixel", 32'(active_pixel), 32'((mx < HA) && (my < VA)));
    check_eq("line_start", 32'(line_start), 32'(mx == 0));
    check_eq("frame_start", 32'(frame_start), 32'((mx == 0) && (my == 0)));
`ifdef VTG_FRAME_CNT_EN
    check_eq("frame_count", 32'(frame_count), 32'(mfc));
`endif
    $display("cyc=%0d rst=%0b en=%0b x=%0d y=%0d hs=%0b vs=%0b act=%0b ls=%0b fs=%0b",
             cyc, rst_v, en_v, x_count, y_count, hsync, vsync, active_pixel,
             line_start, frame_start);
  endtask

  initial begin
    // Reset, including a cycle with en high to show reset dominates.
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    // Two full frames with en held high.
    for (int i = 0; i < 2 * HT * VT; i++) step(1'b1, 1'b0);

    // Clock enable at roughly one cycle in three.
    for (int i = 0; i < 600; i++) step(($urandom_range(0, 2) == 0), 1'b0);

    // Run to a mid-frame blanking position, then reset with en low.
    for (int i = 0; i < 2 * HT * VT && !(mx == HA + 2 && my == VA + 1); i++)
      step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);

    // Random enable with sparse random resets; long enough for frame wraps.
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));

    // Final stretch of uninterrupted frames to exercise frame-level wraps.
    for (int i = 0; i < 3 * HT * VT; i++) step(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator driven by the pixel clock, producing pixel/line counters, sync pulses, active-video flag and line/frame strobes. It generalises the fixed 640x480 sync generator to any mode via parameters, with independent sync polarity, a pixel-clock enable, and registered, glitch-free outputs. It sits at the head of the video pipeline; pixel sources and the output DAC/TMDS stage consume its outputs.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync asserted level (0 = negative)
- V_POL, 0, vsync asserted level (0 = negative)
- CNT_W, 10, counter width
- clk_25  in  1  pixel clock; one clock domain
- rst  in  1  synchronous, active-high reset
- en  in  1  pixel-clock enable; low freezes all state
- x_count  out  CNT_W  current pixel column, 0..H_TOTAL-1
- y_count  out  CNT_W  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level per H_POL
- vsync  out  1  vertical sync, level per V_POL
- active_pixel  out  1  high inside H_ACTIVE x V_ACTIVE region
- line_start  out  1  high while x_count == 0
- frame_start  out  1  high while x_count == 0 and y_count == 0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Elaboration error if any parameter < 1 or a total exceeds 2^CNT_W.
- Each axis runs a 4-state FSM: ACTIVE -> FP -> SYNC -> BP -> ACTIVE, with a phase-local down-counter and the absolute position counter.
- Horizontal axis advances when en=1. Vertical axis advances when en=1 and horizontal is at x = H_TOTAL-1 (wrap).
- Wrap: x = H_TOTAL-1 -> 0; y = V_TOTAL-1 -> 0 on the same edge x wraps.
- hsync asserted (= H_POL) exactly for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]: H_SYNC clocks, not one fewer. Else ~H_POL.
- vsync asserted (= V_POL) for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], changing on line boundaries (aligned to x = 0).
- active_pixel = (x < H_ACTIVE) && (y < V_ACTIVE).
- en=0: counters, FSM states and all outputs hold.

## Timing
- All outputs are registers, mutually consistent: in any cycle, hsync/vsync/active_pixel/strobes correspond to the x_count/y_count presented in that cycle. Zero latency between counter and its decodes.
- Reset values: x_count=0, y_count=0, hsync=~H_POL, vsync=~V_POL, active_pixel=1, line_start=1, frame_start=1, both FSMs in ACTIVE.
- rst mid-frame: next cycle outputs equal reset values regardless of en; counting resumes from (0,0).
- rst dominates en.
- With en held high, line_start is a 1-cycle pulse every H_TOTAL clocks; frame_start every H_TOTAL*V_TOTAL clocks.

## Configuration
- VTG_FRAME_CNT_EN: defined adds output frame_count (16 bits), reset 0, incremented on the edge where (x,y) wraps from (H_TOTAL-1,V_TOTAL-1) to (0,0), wraps 0xFFFF -> 0, holds when en=0. Undefined: port and logic absent; other behaviour identical.

## Structure
- Package vtg_pkg: phase enum (PH_ACTIVE, PH_FP, PH_SYNC, PH_BP) and a function computing total length from the four phase lengths.
- Sub-module vtg_axis (parameters ACTIVE, FP, SYNC, BP, POL, CNT_W; inputs clk_25, rst, tick; outputs count, wrap, sync, active), instantiated twice. Top: tick wiring, AND of active flags, strobes, optional frame counter.

## Test plan
- Defaults, en=1, 2 frames -> frame_start period 420000 clocks; line_start period 800; y_count max 524.
- Defaults -> hsync low exactly x=656..751 (96 clocks); vsync low exactly lines 490..491 (1600 clocks); active_pixel high 307200 clocks per frame.
- Small mode H=4/1/2/1, V=3/1/1/1, H_POL=1, V_POL=1 -> H_TOTAL=8, hsync high at x=5,6; vsync high on y=4; frame period 48.
- en toggled 1-of-3 cycles -> all outputs identical to reference sequence stretched 3x; no output change when en=0.
- rst asserted at x=700,y=300 for one cycle -> next cycle x=0,y=0, hsync=~H_POL, frame_start=1.
- VTG_FRAME_CNT_EN defined, 3 frames -> frame_count 0,1,2,3 stepping exactly at frame_start edges.
